// File: rtl/button_arbiter_if.sv
// Button arbiter bus: raw button levels in, press pulses and status out.
// The slave modport is the arbiter's view; the master modport is the
// view of whatever drives the buttons and consumes the pulses.
interface button_arbiter_if #(
    parameter int NUM_BTN = 4
) ();
    localparam int IW = $clog2(NUM_BTN);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] pulse;
    logic [IW-1:0]      grant_id;
    logic               busy;
    logic [NUM_BTN-1:0] pending;

    modport master (
        output btn_raw,
        input  pulse,
        input  grant_id,
        input  busy,
        input  pending
    );

    modport slave (
        input  btn_raw,
        output pulse,
        output grant_id,
        output busy,
        output pending
    );
endinterface

// File: rtl/button_arbiter.sv
// Shared-lockout button arbiter.
// Each raw button is synchronised and edge-detected; rising edges are latched
// as pending requests. A single lockout timer is shared by all buttons: one
// request is granted (one-cycle pulse), then the arbiter is locked for
// LOCK_CYCLES cycles, which also swallows contact bounce of the granted
// button. Requests arriving meanwhile are kept and served round-robin.
module button_arbiter #(
    parameter int NUM_BTN     = 4,
    parameter int LOCK_CYCLES = 25000000,
    parameter int TW          = $clog2(LOCK_CYCLES)
) (
    input  logic                clk,
    input  logic                reset,
    button_arbiter_if.slave     bus
);
    localparam int IW = $clog2(NUM_BTN);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(NUM_BTN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    // One-hot decode of a button index.
    function automatic logic [NUM_BTN-1:0] onehot_f(input logic [IW-1:0] idx);
        logic [NUM_BTN-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            oh[i] = (IW'(i) == idx);
        end
        return oh;
    endfunction

    // Registers
    logic [NUM_BTN-1:0] r_s1;
    logic [NUM_BTN-1:0] r_s2;
    logic [NUM_BTN-1:0] r_prev;
    logic [NUM_BTN-1:0] r_pending;
    logic [NUM_BTN-1:0] r_pulse;
    logic [IW-1:0]      r_grant_id;
    logic [IW-1:0]      r_last;
    logic [TW-1:0]      r_timer;
    logic               r_busy;
    state_t             r_state;

    // Combinational signals
    logic [NUM_BTN-1:0] w_rise;
    logic [NUM_BTN-1:0] w_mask;
    logic [NUM_BTN-1:0] w_set;
    logic [NUM_BTN-1:0] w_clr;
    logic [NUM_BTN-1:0] w_pending_nxt;
    logic [NUM_BTN-1:0] w_pulse_nxt;
    logic [IW-1:0]      w_idx;
    logic [IW-1:0]      w_sel;
    logic               w_found;
    logic [IW-1:0]      w_grant_nxt;
    logic [IW-1:0]      w_last_nxt;
    logic [TW-1:0]      w_timer_nxt;
    logic               w_busy_nxt;
    state_t             w_state_nxt;

    // Two-flop synchroniser followed by the previous-level register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1   <= bus.btn_raw;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_prev;

    // Discard rises of the button currently being served (bounce).
    always_comb begin
        w_mask = '0;
        if ((r_state == ST_GRANT) || (r_state == ST_LOCK)) begin
            w_mask = onehot_f(r_grant_id);
        end else begin
            w_mask = '0;
        end
    end

    assign w_set = w_rise & ~w_mask;

    // Round-robin pick: first pending bit starting just after the last grant.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_BTN; k++) begin
            w_idx = IW'((int'(r_last) + k) % NUM_BTN);
            if (!w_found && r_pending[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Next-state and datapath decode for the grant/lockout FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_grant_nxt = r_grant_id;
        w_last_nxt  = r_last;
        w_clr       = '0;
        w_pulse_nxt = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = w_sel;
                    w_last_nxt  = w_sel;
                    w_clr       = onehot_f(w_sel);
                    w_pulse_nxt = onehot_f(w_sel);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                w_timer_nxt = LOCK_LOAD;
                w_state_nxt = ST_LOCK;
            end
            ST_LOCK: begin
                if (r_timer == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // A new rise on the same edge as the clear keeps the bit set.
    assign w_pending_nxt = (r_pending & ~w_clr) | w_set;

    // FSM state, lockout timer, pending latch and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_grant_id <= '0;
            r_last     <= LAST_INIT;
            r_pending  <= '0;
            r_pulse    <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_grant_id <= w_grant_nxt;
            r_last     <= w_last_nxt;
            r_pending  <= w_pending_nxt;
            r_pulse    <= w_pulse_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign bus.pulse    = r_pulse;
    assign bus.grant_id = r_grant_id;
    assign bus.busy     = r_busy;
    assign bus.pending  = r_pending;

endmodule

// File: tb/tb_button_arbiter.sv
// Scoreboard bench for button_arbiter (NUM_BTN=4, LOCK_CYCLES=8).
// Stimulus pushes the expected pulse (cycle, bit, grant_id) into a queue;
// a negedge monitor pops an entry for every pulse the DUT produces.
module tb_button_arbiter;
    localparam int NB = 4;
    localparam int LC = 8;

    typedef struct {
        int             cyc;
        logic [NB-1:0]  pls;
        logic [1:0]     gid;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];

    button_arbiter_if #(.NUM_BTN(NB)) bus ();

    button_arbiter #(
        .NUM_BTN    (NB),
        .LOCK_CYCLES(LC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Edge counter: read at negedge it equals the number of rising edges seen.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int c, input int b);
        exp_t e;
        e.cyc    = c;
        e.pls    = '0;
        e.pls[b] = 1'b1;
        e.gid    = 2'(b);
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus.pulse !== '0) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got pulse=%b grant_id=%0d at cycle %0d, expected none",
                         bus.pulse, bus.grant_id, cyc);
            end else begin
                e = sb_q.pop_front();
                chk("pulse_value", 32'(bus.pulse), 32'(e.pls));
                chk("pulse_grant_id", 32'(bus.grant_id), 32'(e.gid));
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        int c;
        int bc;
        int first_b;
        int last_b;
        int hits;

        reset = 1'b1;
        bus.btn_raw = '0;
        tick(3);
        reset = 1'b0;
        chk("reset_pulse", 32'(bus.pulse), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_pending", 32'(bus.pending), 32'd0);
        chk("reset_grant_id", 32'(bus.grant_id), 32'd0);
        tick(5);

        // Test 1: single held press, busy for GRANT + LOCK_CYCLES cycles
        c = cyc;
        bus.btn_raw[2] = 1'b1;
        expect_pulse(c + 4, 2);
        bc = 0; first_b = -1; last_b = -1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (bus.busy === 1'b1) begin
                bc++;
                if (first_b < 0) first_b = cyc;
                last_b = cyc;
            end
        end
        chk("busy_cycle_count", 32'(bc), 32'(LC + 1));
        chk("busy_first_cycle", 32'(first_b), 32'(c + 4));
        chk("busy_last_cycle", 32'(last_b), 32'(c + 12));
        bus.btn_raw[2] = 1'b0;
        tick(5);

        // Test 2: bouncing button yields one pulse, no pending during lock
        c = cyc;
        bus.btn_raw[1] = 1'b1;
        expect_pulse(c + 4, 1);
        hits = 0;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (i >= 4 && bus.pending[1] === 1'b1) hits++;
            if (i == 2) bus.btn_raw[1] = 1'b0;
            if (i == 4) bus.btn_raw[1] = 1'b1;
        end
        chk("bounce_pending_hits", 32'(hits), 32'd0);
        bus.btn_raw[1] = 1'b0;
        tick(5);

        // Test 3: all four pressed together, served 0..3 from reset
        do_reset();
        tick(2);
        c = cyc;
        bus.btn_raw = 4'b1111;
        expect_pulse(c + 4, 0);
        expect_pulse(c + 14, 1);
        expect_pulse(c + 24, 2);
        expect_pulse(c + 34, 3);
        tick(4);
        chk("simul_pending_after_first", 32'(bus.pending), 32'h0000_000E);
        tick(36);
        bus.btn_raw = 4'b0000;
        tick(10);

        // Test 4a: last=3, bits 0 and 3 pending -> bit 0 first
        c = cyc;
        bus.btn_raw = 4'b1001;
        expect_pulse(c + 4, 0);
        expect_pulse(c + 14, 3);
        tick(25);
        bus.btn_raw = 4'b0000;
        tick(5);

        // Test 4b: last=0, bits 1 and 0 together -> bit 1 first
        c = cyc;
        bus.btn_raw = 4'b0001;
        expect_pulse(c + 4, 0);
        tick(6);
        bus.btn_raw = 4'b0000;
        tick(10);
        c = cyc;
        bus.btn_raw = 4'b0011;
        expect_pulse(c + 4, 1);
        expect_pulse(c + 14, 0);
        tick(25);
        bus.btn_raw = 4'b0000;
        tick(5);

        // Test 4c: two rises of bit 2 during lock of bit 3 collapse to one
        c = cyc;
        bus.btn_raw[3] = 1'b1;
        expect_pulse(c + 4, 3);
        tick(6);
        bus.btn_raw[2] = 1'b1;
        tick(2);
        bus.btn_raw[2] = 1'b0;
        tick(2);
        chk("collapse_pending", 32'(bus.pending), 32'h0000_0004);
        bus.btn_raw[2] = 1'b1;
        expect_pulse(c + 14, 2);
        tick(30);
        bus.btn_raw = 4'b0000;
        tick(5);

        // Test 5: reset mid-lock with bit 3 pending
        c = cyc;
        bus.btn_raw[2] = 1'b1;
        expect_pulse(c + 4, 2);
        tick(5);
        bus.btn_raw[3] = 1'b1;
        tick(3);
        chk("midlock_pending_before_reset", 32'(bus.pending), 32'h0000_0008);
        chk("midlock_busy_before_reset", 32'(bus.busy), 32'd1);
        bus.btn_raw = 4'b0000;
        do_reset();
        chk("midlock_reset_pending", 32'(bus.pending), 32'd0);
        chk("midlock_reset_busy", 32'(bus.busy), 32'd0);
        chk("midlock_reset_grant_id", 32'(bus.grant_id), 32'd0);
        tick(20);
        c = cyc;
        bus.btn_raw[3] = 1'b1;
        expect_pulse(c + 4, 3);
        tick(15);
        bus.btn_raw = 4'b0000;
        tick(5);

        // Test 6: held press gives one pulse; re-press gives another
        c = cyc;
        bus.btn_raw[0] = 1'b1;
        expect_pulse(c + 4, 0);
        tick(100);
        bus.btn_raw[0] = 1'b0;
        tick(10);
        c = cyc;
        bus.btn_raw[0] = 1'b1;
        expect_pulse(c + 4, 0);
        tick(20);
        bus.btn_raw = 4'b0000;
        tick(5);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/button_arbiter.md
Name: button_arbiter

Overview:
- Shares a single lockout timer among NUM_BTN raw push-buttons.
- Converts each accepted press into a one-cycle pulse on that button's pulse bit.
- Presses that arrive while the timer is busy are latched as pending and served round-robin once the lockout expires, so they are not lost.
- Sits between the board buttons and the user-logic FSMs, replacing one debouncer per button.

Parameters:
- NUM_BTN, 4, number of button inputs (2..8).
- LOCK_CYCLES, 25000000, lockout length in clk cycles after each pulse (250 ms at 100 MHz). Must be ≥ 2.
- TW, $clog2(LOCK_CYCLES), width of the lockout timer.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_raw  input  NUM_BTN  asynchronous raw button levels, active-high.
- pulse  output  NUM_BTN  one-hot, one-cycle press pulse.
- grant_id  output  $clog2(NUM_BTN)  index of the last granted button.
- busy  output  1  high in GRANT and LOCK states.
- pending  output  NUM_BTN  latched, not-yet-served presses.

Behaviour:
- Reset (sampled on a clk edge with reset=1):
  - sync stages, prev, pending, pulse all 0.
  - grant_id=0, last=NUM_BTN-1, timer=0, state=IDLE, busy=0.
  - Reset overrides everything, including mid-LOCK. The next state is IDLE with all pending cleared.
- Input path, per bit:
  - Two-flop synchronizer s1→s2, then a prev register.
  - rise[i] = s2[i] & ~prev[i] (combinational).
  - Falling edges are ignored.
- Pending register:
  - pending[i] is set on the edge where rise[i]=1.
  - It is cleared on the edge leaving IDLE with i selected.
  - If clear and set coincide for the same bit, set wins.
  - Exception: while state is GRANT or LOCK, rise[grant_id] is masked, so bounce of the served button is discarded.
  - Rises on other buttons during GRANT/LOCK are latched normally.
- State machine:
  - IDLE:
    - If pending==0, stay.
    - Otherwise select the first set bit scanning (last+1) mod NUM_BTN upward with wrap.
    - Set grant_id=sel, last=sel, clear pending[sel], go to GRANT.
  - GRANT (exactly 1 cycle):
    - pulse[grant_id]=1, all other pulse bits 0.
    - timer←LOCK_CYCLES-1, go to LOCK.
  - LOCK:
    - If timer==0 go to IDLE, else timer←timer-1.
    - pulse=0 throughout.
  - Illegal encodings go to IDLE.
- pulse is a registered-state decode (state==GRANT), with no combinational path from btn_raw.
- Timing:
  - Latency: btn_raw high before edge k → pulse high in the cycle after edge k+3 (4 cycles).
  - LOCK lasts exactly LOCK_CYCLES cycles.
  - Minimum pulse-to-pulse spacing is LOCK_CYCLES+2 cycles: GRANT, then LOCK, then at least 1 IDLE cycle.
- Boundary cases:
  - All buttons pressed on the same cycle: served 0,1,2,3 from reset, one per lockout period.
  - A button held continuously produces exactly one pulse. It must be released and pressed again to produce another.
  - Multiple rises of the same non-served button during LOCK collapse into a single pending bit.

Test Plan:
1. Reset, LOCK_CYCLES=8, NUM_BTN=4:
   - Raise btn_raw[2] at cycle 10 and hold → pulse=4'b0100 for exactly one cycle at cycle 14.
   - busy is high for cycles 14..22, no further pulses.
2. Bounce: btn_raw[1] toggles 0/1 every 2 cycles for 6 cycles, then stays high → exactly one pulse[1], and pending[1] is never set during LOCK.
3. Simultaneous press: btn_raw=4'b1111 at cycle 10 → pulses at cycles 14, 24, 34, 44 on bits 0, 1, 2, 3, with grant_id following 0..3.
4. Round-robin fairness:
   - After granting bit 3, bits 0 and 3 are pending → bit 0 is served first.
   - Then press bits 1 and 0 together → bit 1 is served before bit 0.
5. Reset mid-LOCK: assert reset for 1 cycle at cycle 18 of test 1 while bit 3 is pending → state IDLE, pending=0, no pulse afterwards until a new rise.
6. Held press across lockout: btn_raw[0] held for 100 cycles → one pulse. Release, then press again → second pulse 4 cycles after the new rise.
